// File: rtl/seg_scan_decoder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// seg_scan_decoder : recovers digit codes and frames from an active-low 7-seg scan bus
// Rev 1.0
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DIGITS-1:0]     i_sel,
  input  logic [6:0]            i_seg,
  input  logic                  i_dp,
  output logic [4*DIGITS-1:0]   o_data,
  output logic [DIGITS-1:0]     o_dp,
  output logic                  o_valid,
  output logic                  o_err
);

  localparam int          c_SW     = DIGITS + 8;
  localparam logic [7:0]  c_STABLE = 8'(STABLE);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [c_SW-1:0]        in_q;
  logic [7:0]             cnt_q, cnt_d;
  logic [4*DIGITS-1:0]    shd_data_q, shd_data_d;
  logic [DIGITS-1:0]      shd_dp_q, shd_dp_d;
  logic [DIGITS-1:0]      mask_q, mask_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic [4*DIGITS-1:0]    data_q, data_d;
  logic [DIGITS-1:0]      dp_q, dp_d;
  logic                   valid_q;
  logic                   oerr_q, oerr_d;

  logic [c_SW-1:0]        w_smp;
  logic                   w_smp_ok;
  logic                   w_same;
  logic                   w_cap;
  logic [3:0]             w_code;
  logic [DIGITS-1:0]      w_rsel;

  function automatic logic f_sel_ok(input logic [DIGITS-1:0] sel);
    logic [DIGITS-1:0] a;
    a = ~sel;
    return (a != '0) && ((a & (a - DIGITS'(1))) == '0);
  endfunction

  function automatic logic [3:0] f_decode(input logic [6:0] seg);
    case (seg)
      7'h40:   return 4'h0;
      7'h79:   return 4'h1;
      7'h24:   return 4'h2;
      7'h30:   return 4'h3;
      7'h19:   return 4'h4;
      7'h12:   return 4'h5;
      7'h02:   return 4'h6;
      7'h78:   return 4'h7;
      7'h00:   return 4'h8;
      7'h10:   return 4'h9;
      7'h3F:   return 4'hA;
      7'h7F:   return 4'hF;
      default: return 4'hE;
    endcase
  endfunction

  // The incoming sample is compared against in_q, which becomes the previous
  // sample on the same edge, so the count is already 1 when a new value lands.
  always_comb begin
    w_smp    = {i_sel, i_seg, i_dp};
    w_smp_ok = f_sel_ok(i_sel);
    w_same   = w_smp_ok && (w_smp == in_q);
    w_rsel   = in_q[c_SW-1:8];
    w_code   = f_decode(in_q[7:1]);

    if (!w_smp_ok)            cnt_d = 8'd0;
    else if (!w_same)         cnt_d = 8'd1;
    else if (cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
    else                      cnt_d = cnt_q;

    state_d = state_q;
    case (state_q)
      ST_WAIT:    if (cnt_d == c_STABLE) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = w_same ? ST_HOLD : ST_WAIT;
      ST_HOLD:    if (!w_same) state_d = ST_WAIT;
      default:    state_d = ST_WAIT;
    endcase

    // The write needs the pattern to survive one edge past the dwell target.
    w_cap = (state_q == ST_CAPTURE) && w_same;
  end

  always_comb begin
    shd_data_d = shd_data_q;
    shd_dp_d   = shd_dp_q;
    mask_d     = mask_q;
    err_d      = err_q;
    data_d     = data_q;
    dp_d       = dp_q;
    oerr_d     = oerr_q;

    if (done_q) begin
      data_d = shd_data_q;
      dp_d   = shd_dp_q;
      oerr_d = err_q;
      mask_d = '0;
      err_d  = 1'b0;
    end

    if (w_cap) begin
      for (int n = 0; n < DIGITS; n++) begin
        if (!w_rsel[n]) begin
          shd_data_d[4*n +: 4] = w_code;
          shd_dp_d[n]          = ~in_q[0];
          mask_d[n]            = 1'b1;
        end
      end
      if (w_code == 4'hE) err_d = 1'b1;
    end

    done_d = w_cap && (&mask_d);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_WAIT;
      in_q       <= '1;
      cnt_q      <= '0;
      shd_data_q <= '1;
      shd_dp_q   <= '0;
      mask_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '1;
      dp_q       <= '0;
      valid_q    <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_q       <= w_smp;
      cnt_q      <= cnt_d;
      shd_data_q <= shd_data_d;
      shd_dp_q   <= shd_dp_d;
      mask_q     <= mask_d;
      err_q      <= err_d;
      done_q     <= done_d;
      data_q     <= data_d;
      dp_q       <= dp_d;
      valid_q    <= done_q;
      oerr_q     <= oerr_d;
    end
  end

  assign o_data  = data_q;
  assign o_dp    = dp_q;
  assign o_valid = valid_q;
  assign o_err   = oerr_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder : directed table-driven bench for seg_scan_decoder
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sel;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] o_data;
  logic [3:0]  o_dp;
  logic        o_valid;
  logic        o_err;

  always #5 clk = ~clk;

  seg_scan_decoder #(.DIGITS(4), .STABLE(4)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_sel   (sel),
    .i_seg   (seg),
    .i_dp    (dp),
    .o_data  (o_data),
    .o_dp    (o_dp),
    .o_valid (o_valid),
    .o_err   (o_err)
  );

  int          cyc = 0;
  int          pulses = 0;
  int          pulse_cyc = 0;
  logic [15:0] cap_data;
  logic [3:0]  cap_dp;
  logic        cap_err;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      pulses    = pulses + 1;
      pulse_cyc = cyc;
      cap_data  = o_data;
      cap_dp    = o_dp;
      cap_err   = o_err;
    end
  end

  typedef struct {
    logic [27:0] segs;
    logic [3:0]  dpl;
    logic [15:0] exp_data;
    logic [3:0]  exp_dp;
    logic        exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic show(input int n, input logic [6:0] s, input logic d, input int cycles);
    sel = 4'b1111 ^ (4'b0001 << n);
    seg = s;
    dp  = d;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic blank(input int cycles);
    sel = 4'b1111;
    seg = 7'h7F;
    dp  = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic run_frame(input logic [27:0] segs, input logic [3:0] dpl, input int dw0);
    show(0, segs[6:0],   dpl[0], dw0);
    show(1, segs[13:7],  dpl[1], 8);
    show(2, segs[20:14], dpl[2], 8);
    show(3, segs[27:21], dpl[3], 8);
    blank(3);
  endtask

  int          base;
  int          start;
  logic [27:0] s;

  initial begin
    vecs[0] = '{segs: {7'h19, 7'h30, 7'h24, 7'h79}, dpl: 4'b1011,
                exp_data: 16'h4321, exp_dp: 4'b0100, exp_err: 1'b0};
    vecs[1] = '{segs: {7'h55, 7'h30, 7'h24, 7'h79}, dpl: 4'b1111,
                exp_data: 16'hE321, exp_dp: 4'b0000, exp_err: 1'b1};
    vecs[2] = '{segs: {7'h19, 7'h30, 7'h24, 7'h79}, dpl: 4'b1111,
                exp_data: 16'h4321, exp_dp: 4'b0000, exp_err: 1'b0};
    vecs[3] = '{segs: {7'h12, 7'h10, 7'h78, 7'h02}, dpl: 4'b0110,
                exp_data: 16'h5976, exp_dp: 4'b1001, exp_err: 1'b0};

    // Reset with random bus activity
    rst = 1'b1;
    sel = 4'($urandom);
    seg = 7'($urandom);
    dp  = 1'($urandom);
    repeat (2) @(negedge clk);
    check("reset_data",  32'(o_data),  32'hFFFF);
    check("reset_dp",    32'(o_dp),    32'h0);
    check("reset_valid", 32'(o_valid), 32'h0);
    check("reset_err",   32'(o_err),   32'h0);
    rst = 1'b0;
    blank(2);

    for (int i = 0; i < 4; i++) begin
      base = pulses;
      run_frame(vecs[i].segs, vecs[i].dpl, 8);
      check($sformatf("v%0d_pulses", i), 32'(pulses - base), 32'd1);
      check($sformatf("v%0d_data", i),   32'(cap_data),      32'(vecs[i].exp_data));
      check($sformatf("v%0d_dp", i),     32'(cap_dp),        32'(vecs[i].exp_dp));
      check($sformatf("v%0d_err", i),    32'(cap_err),       32'(vecs[i].exp_err));
    end

    // Short dwell on digit 0, then a long enough revisit
    s    = vecs[2].segs;
    base = pulses;
    run_frame(s, 4'b1111, 4);
    check("short_no_pulse", 32'(pulses - base), 32'd0);
    show(0, s[6:0], 1'b1, 5);
    blank(3);
    check("short_pulse", 32'(pulses - base), 32'd1);
    check("short_data",  32'(cap_data),      32'h4321);

    // Blanking and multi-select glitches between digits, plus frame latency
    base = pulses;
    show(0, s[6:0], 1'b1, 8);
    blank(2);
    sel = 4'b1100; seg = 7'h00; dp = 1'b0;
    @(negedge clk);
    show(1, s[13:7], 1'b1, 8);
    blank(2);
    show(2, s[20:14], 1'b0, 8);
    sel = 4'b1100; seg = 7'h00; dp = 1'b0;
    @(negedge clk);
    blank(2);
    start = cyc;
    show(3, s[27:21], 1'b1, 8);
    blank(3);
    check("glitch_pulse",   32'(pulses - base),    32'd1);
    check("glitch_data",    32'(cap_data),         32'h4321);
    check("glitch_dp",      32'(cap_dp),           32'h4);
    check("glitch_latency", 32'(pulse_cyc - start), 32'd6);

    // Reset after two captures discards the partial frame
    s    = {7'h00, 7'h40, 7'h3F, 7'h7F};
    base = pulses;
    show(0, 7'h79, 1'b1, 8);
    show(1, 7'h24, 1'b1, 8);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    blank(3);
    check("midrst_no_pulse", 32'(pulses - base), 32'd0);
    check("midrst_data",     32'(o_data),        32'hFFFF);
    check("midrst_valid",    32'(o_valid),       32'h0);
    show(2, s[20:14], 1'b1, 8);
    show(3, s[27:21], 1'b1, 8);
    blank(3);
    check("midrst_partial", 32'(pulses - base), 32'd0);
    show(0, s[6:0],  1'b1, 8);
    show(1, s[13:7], 1'b1, 8);
    blank(3);
    check("blankA_pulse", 32'(pulses - base), 32'd1);
    check("blankA_data",  32'(cap_data),      32'h80AF);
    check("blankA_err",   32'(cap_err),       32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
